bist_session_ctrl: RTL and testbench

Consumer side of the idle-detection handshake. It waits for idle_trigger, takes over the unit under test (UUT) through bist_sel, and streams LFSR patterns to it. UUT responses are compressed into a MISR and compared against a golden signature. The session yields to the system with zero-cycle latency whenever system_valid rises. It sits between the idle detector and the UUT input mux.

---
 rtl/bist_session_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bist_session_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_session_ctrl.sv
// BIST session controller: takes the UUT over during idle windows, streams LFSR
// patterns, compresses responses into a MISR and checks it against a golden signature.
module bist_session_ctrl #(
  parameter int unsigned          DATA_W        = 32,
  parameter int unsigned          NUM_PATTERNS  = 64,
  parameter logic [DATA_W-1:0]    POLY          = DATA_W'(32'h04C11DB7),
  parameter logic [DATA_W-1:0]    SEED          = DATA_W'(32'hACE1_0001),
  parameter int unsigned          OUTST_W       = 8,
  parameter int unsigned          DRAIN_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bist_enable,
  input  logic              idle_trigger,
  input  logic              system_valid,
  input  logic [DATA_W-1:0] golden_sig,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              bist_sel,
  output logic              pat_valid,
  output logic [DATA_W-1:0] pat_data,
  output logic              bist_busy,
  output logic              session_done,
  output logic              session_pass,
  output logic              session_fail,
  output logic              timeout_err,
  output logic [7:0]        abort_cnt
);

  localparam int unsigned IDX_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam int unsigned DRN_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);
  localparam logic [DRN_W-1:0] DRN_MAX  = DRN_W'(DRAIN_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } state_e;

  state_e              state_q;
  logic                armed_q;
  logic [DATA_W-1:0]   lfsr_q;
  logic [DATA_W-1:0]   misr_q;
  logic [IDX_W-1:0]    pat_idx_q;
  logic [OUTST_W-1:0]  outst_q;
  logic [DRN_W-1:0]    drain_cnt_q;
  logic                done_q;
  logic                pass_q;
  logic                fail_q;
  logic                tmo_q;
  logic [7:0]          abort_cnt_q;

  logic                in_session;
  logic                abort;
  logic                rsp_acc;
  logic                start;
  logic [DATA_W-1:0]   lfsr_d;
  logic [DATA_W-1:0]   misr_d;
  logic [OUTST_W-1:0]  outst_d;

  // System traffic wins immediately: the gating below has no register in the path.
  assign in_session = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign abort      = in_session && (system_valid || !bist_enable);
  assign rsp_acc    = in_session && !abort && rsp_valid;
  assign start      = (state_q == S_IDLE) && bist_enable && idle_trigger
                      && !system_valid && armed_q;

  assign bist_sel     = in_session && !system_valid;
  assign pat_valid    = (state_q == S_RUN) && !system_valid && bist_enable;
  assign pat_data     = lfsr_q;
  assign bist_busy    = in_session || (state_q == S_CHECK);
  assign session_done = done_q;
  assign session_pass = pass_q;
  assign session_fail = fail_q;
  assign timeout_err  = tmo_q;
  assign abort_cnt    = abort_cnt_q;

  assign lfsr_d = {lfsr_q[DATA_W-2:0], 1'b0} ^ (lfsr_q[DATA_W-1] ? POLY : '0);
  assign misr_d = ({misr_q[DATA_W-2:0], 1'b0} ^ (misr_q[DATA_W-1] ? POLY : '0)) ^ rsp_data;

  // A pattern issued and a response accepted in the same cycle cancel out.
  always_comb begin
    outst_d = outst_q;
    if (pat_valid && !rsp_acc) begin
      if (outst_q != '1) outst_d = outst_q + OUTST_W'(1);
    end else if (rsp_acc && !pat_valid) begin
      if (outst_q != '0) outst_d = outst_q - OUTST_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b1;
      lfsr_q      <= SEED;
      misr_q      <= '0;
      pat_idx_q   <= '0;
      outst_q     <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      tmo_q       <= 1'b0;
      abort_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      tmo_q  <= 1'b0;
      if (!idle_trigger) armed_q <= 1'b1;
      if (rsp_acc) misr_q <= misr_d;
      outst_q <= outst_d;
      if (abort && (abort_cnt_q != 8'hFF)) abort_cnt_q <= abort_cnt_q + 8'd1;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_RUN;
            lfsr_q    <= SEED;
            misr_q    <= '0;
            pat_idx_q <= '0;
            outst_q   <= '0;
            armed_q   <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else begin
            lfsr_q    <= lfsr_d;
            pat_idx_q <= pat_idx_q + IDX_W'(1);
            if (pat_idx_q == LAST_IDX) begin
              state_q     <= S_DRAIN;
              drain_cnt_q <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRN_W'(1);
            if (outst_d == '0) begin
              state_q <= S_CHECK;
            end else if (drain_cnt_q == DRN_MAX) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              fail_q  <= 1'b1;
              tmo_q   <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          pass_q  <= (misr_q == golden_sig);
          fail_q  <= (misr_q != golden_sig);
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_session_ctrl.sv
// Bench for bist_session_ctrl: directed session table, corner sequences and a
// randomized phase, all checked every cycle against a session-level reference model.
module tb_bist_session_ctrl;

  localparam int          NP     = 64;
  localparam int          DT     = 255;
  localparam logic [31:0] POLY_C = 32'h04C11DB7;
  localparam logic [31:0] SEED_C = 32'hACE1_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bist_enable, idle_trigger, system_valid, rsp_valid;
  logic [31:0] golden_sig, rsp_data;
  logic        bist_sel, pat_valid, bist_busy;
  logic        session_done, session_pass, session_fail, timeout_err;
  logic [31:0] pat_data;
  logic [7:0]  abort_cnt;

  always #5 clk = ~clk;

  bist_session_ctrl #(
    .DATA_W(32), .NUM_PATTERNS(NP), .POLY(POLY_C), .SEED(SEED_C),
    .OUTST_W(8), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bist_enable(bist_enable), .idle_trigger(idle_trigger),
    .system_valid(system_valid), .golden_sig(golden_sig), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .bist_sel(bist_sel), .pat_valid(pat_valid), .pat_data(pat_data),
    .bist_busy(bist_busy), .session_done(session_done), .session_pass(session_pass),
    .session_fail(session_fail), .timeout_err(timeout_err), .abort_cnt(abort_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] adv(input logic [31:0] x);
    return (x << 1) ^ (x[31] ? POLY_C : 32'h0);
  endfunction

  function automatic logic [31:0] pattern_at(input int k);
    logic [31:0] x = SEED_C;
    repeat (k) x = adv(x);
    return x;
  endfunction

  // Reference model: session phase plus counts of issued patterns and accepted responses.
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_CHECK = 3, PH_DONE = 4;
  int          m_phase, m_issued, m_pending, m_wait, m_aborts;
  bit          m_armed, r_pass, r_fail, r_tmo;
  logic [31:0] m_acc[$];

  function automatic logic [31:0] sig_of_acc();
    logic [31:0] m = 32'h0;
    foreach (m_acc[i]) m = adv(m) ^ m_acc[i];
    return m;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_issued = 0; m_pending = 0; m_wait = 0; m_aborts = 0;
    m_armed = 1'b1; r_pass = 1'b0; r_fail = 1'b0; r_tmo = 1'b0;
    m_acc.delete();
  endtask

  // UUT echo pipeline (2-cycle latency) and observation flags
  bit          p1_v, p2_v;
  logic [31:0] p1_d, p2_d;
  int          drop_from = NP;
  bit          rand_rsp = 1'b0, golden_auto = 1'b0, golden_flip = 1'b0;
  bit          capture_now = 1'b0, cap_sel, cap_pv;
  int          obs_pv;
  logic [31:0] first_pd;
  bit          obs_done, obs_pass, obs_fail, obs_tmo, obs_busy;

  task automatic clear_obs();
    obs_pv = 0; first_pd = 32'h0;
    obs_done = 0; obs_pass = 0; obs_fail = 0; obs_tmo = 0; obs_busy = 0;
  endtask

  // One clock cycle: entered and left at posedge+1 with the caller's inputs applied.
  task automatic tick();
    bit sess, e_sel, e_pv, e_busy, e_done, abrt, acc;
    logic [31:0] e_pd;
    if (rand_rsp) begin
      rsp_valid = (p2_v && ($urandom_range(9) != 0)) || ($urandom_range(29) == 0);
      rsp_data  = p2_v ? p2_d : $urandom;
    end else begin
      rsp_valid = p2_v;
      rsp_data  = p2_d;
    end
    if (golden_auto) golden_sig = sig_of_acc() ^ {31'b0, golden_flip};
    #1;
    sess   = (m_phase == PH_RUN) || (m_phase == PH_DRAIN);
    e_sel  = sess && !system_valid;
    e_pv   = (m_phase == PH_RUN) && !system_valid && bist_enable;
    e_pd   = pattern_at(m_issued);
    e_busy = sess || (m_phase == PH_CHECK);
    e_done = (m_phase == PH_DONE);
    chk("bist_sel", bist_sel, e_sel);
    chk("pat_valid", pat_valid, e_pv);
    chk("pat_data", pat_data, e_pd);
    chk("bist_busy", bist_busy, e_busy);
    chk("session_done", session_done, e_done);
    chk("session_pass", session_pass, e_done && r_pass);
    chk("session_fail", session_fail, e_done && r_fail);
    chk("timeout_err", timeout_err, e_done && r_tmo);
    chk("abort_cnt", abort_cnt, (m_aborts > 255) ? 255 : m_aborts);
    if (capture_now) begin cap_sel = bist_sel; cap_pv = pat_valid; end
    if (pat_valid) begin
      if (obs_pv == 0) first_pd = pat_data;
      obs_pv++;
    end
    obs_done |= session_done; obs_pass |= session_pass;
    obs_fail |= session_fail; obs_tmo |= timeout_err; obs_busy |= bist_busy;
    p2_v = p1_v; p2_d = p1_d;
    p1_v = pat_valid && (m_issued < drop_from);
    p1_d = pat_data;

    abrt = sess && (system_valid || !bist_enable);
    acc  = sess && !abrt && rsp_valid;
    case (m_phase)
      PH_IDLE: begin
        if (bist_enable && idle_trigger && !system_valid && m_armed) begin
          m_phase = PH_RUN; m_issued = 0; m_pending = 0; m_armed = 1'b0;
          m_acc.delete();
        end
      end
      PH_RUN, PH_DRAIN: begin
        if (abrt) begin
          m_aborts++;
          m_phase = PH_IDLE;
        end else begin
          if (acc) m_acc.push_back(rsp_data);
          m_pending = m_pending + int'(e_pv) - int'(acc);
          if (m_pending < 0) m_pending = 0;
          if (m_phase == PH_RUN) begin
            m_issued++;
            if (m_issued == NP) begin m_phase = PH_DRAIN; m_wait = 0; end
          end else begin
            if (m_pending == 0) m_phase = PH_CHECK;
            else if (m_wait == DT) begin
              m_phase = PH_DONE; r_pass = 0; r_fail = 1; r_tmo = 1;
            end
            m_wait++;
          end
        end
      end
      PH_CHECK: begin
        r_pass = (sig_of_acc() == golden_sig); r_fail = !r_pass; r_tmo = 0;
        m_phase = PH_DONE;
      end
      default: m_phase = PH_IDLE;
    endcase
    if (!idle_trigger) m_armed = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int flip; int drop; int abort_at;
    bit x_done; bit x_pass; bit x_fail; bit x_tmo; int x_pats; int x_ab;
  } row_t;
  row_t        rows[4];
  logic [31:0] golden_good;

  task automatic run_row(input row_t r, input int id);
    int  n = 0, since = 0, base;
    bit  aborted = 0;
    base = m_aborts;
    drop_from = NP - r.drop;
    rand_rsp = 0; golden_auto = 0;
    golden_sig = golden_good ^ 32'(r.flip);
    bist_enable = 1; system_valid = 0; idle_trigger = 0;
    tick();
    idle_trigger = 1;
    clear_obs();
    while (n < 800 && !obs_done && !(aborted && since >= 3)) begin
      system_valid = (r.abort_at >= 0) && !aborted && (m_phase == PH_RUN)
                     && (m_issued == r.abort_at);
      capture_now = system_valid;
      if (system_valid) aborted = 1; else if (aborted) since++;
      tick();
      capture_now = 0;
      n++;
    end
    system_valid = 0;
    if (n >= 800) begin
      total++; bad++;
      $display("FAIL row%0d cycle budget expired got=%0d exp<800", id, n);
    end
    chk($sformatf("row%0d done", id), obs_done, r.x_done);
    chk($sformatf("row%0d pass", id), obs_pass, r.x_pass);
    chk($sformatf("row%0d fail", id), obs_fail, r.x_fail);
    chk($sformatf("row%0d timeout", id), obs_tmo, r.x_tmo);
    chk($sformatf("row%0d pattern count", id), obs_pv, r.x_pats);
    chk($sformatf("row%0d first pattern", id), first_pd, SEED_C);
    chk($sformatf("row%0d abort_cnt", id), abort_cnt,
        (base + r.x_ab > 255) ? 255 : base + r.x_ab);
    if (aborted) begin
      chk($sformatf("row%0d sel in abort cycle", id), cap_sel, 0);
      chk($sformatf("row%0d pat_valid in abort cycle", id), cap_pv, 0);
    end
  endtask

  initial begin
    logic [31:0] x;
    rows[0] = '{0, 0, -1, 1, 1, 0, 0, NP, 0};
    rows[1] = '{1, 0, -1, 1, 0, 1, 0, NP, 0};
    rows[2] = '{0, 0, 10, 0, 0, 0, 0, 10, 1};
    rows[3] = '{0, 3, -1, 1, 0, 1, 1, NP, 0};
    x = SEED_C; golden_good = 32'h0;
    for (int i = 0; i < NP; i++) begin
      golden_good = adv(golden_good) ^ x;
      x = adv(x);
    end

    rst_n = 0; bist_enable = 0; idle_trigger = 0; system_valid = 0;
    rsp_valid = 0; rsp_data = 0; golden_sig = 0;
    p1_v = 0; p2_v = 0; p1_d = 0; p2_d = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset bist_sel", bist_sel, 0);
    chk("reset pat_valid", pat_valid, 0);
    chk("reset bist_busy", bist_busy, 0);
    chk("reset session_done", session_done, 0);
    chk("reset abort_cnt", abort_cnt, 0);
    rst_n = 1;
    model_reset();
    clear_obs();

    for (int i = 0; i < 4; i++) run_row(rows[i], i);

    // idle_trigger held high after a passing session must not start another one
    run_row(rows[0], 4);
    clear_obs();
    repeat (60) tick();
    chk("no session without rearm", obs_busy, 0);
    run_row(rows[0], 5);

    // idle_trigger and system_valid together: no start until system_valid drops
    idle_trigger = 0; tick();
    idle_trigger = 1; system_valid = 1;
    clear_obs();
    tick();
    system_valid = 0;
    tick();
    chk("simultaneous trigger no start", obs_busy, 0);
    tick();
    chk("start after system_valid drops", bist_busy, 1);
    system_valid = 1; tick(); system_valid = 0;

    repeat (300) begin
      idle_trigger = 0; tick();
      idle_trigger = 1; tick();
      system_valid = 1; tick();
      system_valid = 0;
    end
    chk("abort_cnt saturated", abort_cnt, 255);

    // asynchronous reset in the middle of RUN
    idle_trigger = 0; tick();
    idle_trigger = 1;
    repeat (6) tick();
    chk("pre-reset bist_sel", bist_sel, 1);
    #2 rst_n = 0;
    #1;
    chk("async rst bist_sel", bist_sel, 0);
    chk("async rst pat_valid", pat_valid, 0);
    chk("async rst bist_busy", bist_busy, 0);
    chk("async rst session_done", session_done, 0);
    chk("async rst session_fail", session_fail, 0);
    chk("async rst abort_cnt", abort_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    p1_v = 0; p2_v = 0;

    rand_rsp = 1; golden_auto = 1; drop_from = NP;
    repeat (3000) begin
      system_valid = ($urandom_range(149) == 0);
      bist_enable  = ($urandom_range(299) != 0);
      if ($urandom_range(59) == 0) idle_trigger = !idle_trigger;
      golden_flip  = $urandom_range(1) != 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
